// File: rtl/servo_pwm_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_gen_if
// Purpose  : Request/output bundle between the servo position controller
//            (master) and the servo pulse generator (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface servo_pwm_gen_if;
    logic        enable;         // pulse output enable, sampled at frame boundary
    logic [18:0] pwm_cnt;        // requested pulse width in clk cycles
    logic        O_pwm;          // servo pulse
    logic        O_frame_start;  // one-cycle strobe at period_cnt==0
    logic        O_clamped;      // current frame's request was out of range

    modport master (
        output enable,
        output pwm_cnt,
        input  O_pwm,
        input  O_frame_start,
        input  O_clamped
    );

    modport slave (
        input  enable,
        input  pwm_cnt,
        output O_pwm,
        output O_frame_start,
        output O_clamped
    );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_gen
// Purpose  : Fixed-period servo pulse generator. Pulse width is clamped to
//            MIN_CNT..MAX_CNT and only updated at frame boundaries.
//            Optional macro SERVO_SLEW_EN limits width change per frame to
//            SLEW_STEP cycles.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_gen #(
    parameter int PERIOD    = 1000000,
    parameter int MIN_CNT   = 18000,
    parameter int MAX_CNT   = 130000,
    parameter int INIT_CNT  = 74250,
    parameter int SLEW_STEP = 2000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    servo_pwm_gen_if.slave     bus
);

    localparam logic [19:0] c_PERIOD_LAST = 20'(PERIOD - 1);
    localparam logic [18:0] c_MIN         = 19'(MIN_CNT);
    localparam logic [18:0] c_MAX         = 19'(MAX_CNT);
    localparam logic [18:0] c_INIT        = 19'(INIT_CNT);

`ifdef SERVO_SLEW_EN
    localparam bit c_SLEW_ON = 1'b1;
`else
    localparam bit c_SLEW_ON = 1'b0;
`endif
    // Without slew limiting the step limit exceeds any possible width
    // difference, so the target is always taken directly.
    localparam logic [19:0] c_STEP_LIM = c_SLEW_ON ? 20'(SLEW_STEP) : 20'hFFFFF;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [19:0] r_period_cnt;
    logic [18:0] r_width;
    logic [0:0]  r_state;
    logic        r_pwm;
    logic        r_frame_start;
    logic        r_clamped;

    logic        w_boundary;
    logic [19:0] w_period_next;
    logic [18:0] w_target;
    logic        w_clamp_req;
    logic [19:0] w_tgt_ext;
    logic [19:0] w_wid_ext;
    logic [18:0] w_slewed;
    logic [18:0] w_width_next;
    logic [0:0]  w_state_next;
    logic        w_clamped_next;
    logic        w_pwm_next;

    // Next-state computation: counter wrap, clamp, slew and pulse decision
    always_comb begin
        w_boundary    = (r_period_cnt == c_PERIOD_LAST);
        w_period_next = w_boundary ? 20'd0 : (r_period_cnt + 20'd1);

        // Unsigned compare: an upstream underflow wrap lands on c_MAX
        if (bus.pwm_cnt < c_MIN) begin
            w_target = c_MIN;
        end else if (bus.pwm_cnt > c_MAX) begin
            w_target = c_MAX;
        end else begin
            w_target = bus.pwm_cnt;
        end
        w_clamp_req = (bus.pwm_cnt != w_target);

        w_tgt_ext = {1'b0, w_target};
        w_wid_ext = {1'b0, r_width};
        w_slewed  = w_target;
        if (w_tgt_ext > w_wid_ext) begin
            if ((w_tgt_ext - w_wid_ext) > c_STEP_LIM) begin
                w_slewed = 19'(w_wid_ext + c_STEP_LIM);
            end
        end else if (w_wid_ext > w_tgt_ext) begin
            if ((w_wid_ext - w_tgt_ext) > c_STEP_LIM) begin
                w_slewed = 19'(w_wid_ext - c_STEP_LIM);
            end
        end

        w_width_next   = w_boundary ? w_slewed : r_width;
        w_state_next   = w_boundary ? (bus.enable ? c_ST_RUN : c_ST_IDLE) : r_state;
        w_clamped_next = w_boundary ? w_clamp_req : r_clamped;
        w_pwm_next     = (w_state_next == c_ST_RUN) &&
                         (w_period_next < {1'b0, w_width_next});
    end

    // Frame counter, width/state registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt  <= 20'd0;
            r_width       <= c_INIT;
            r_state       <= c_ST_IDLE;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
            r_clamped     <= 1'b0;
        end else begin
            r_period_cnt  <= w_period_next;
            r_width       <= w_width_next;
            r_state       <= w_state_next;
            r_pwm         <= w_pwm_next;
            r_frame_start <= w_boundary;
            r_clamped     <= w_clamped_next;
        end
    end

    assign bus.O_pwm         = r_pwm;
    assign bus.O_frame_start = r_frame_start;
    assign bus.O_clamped     = r_clamped;

endmodule
`default_nettype wire
